// File: rtl/tx_nchar_dispatch.sv
// tx_nchar_dispatch
// Transmit-side scheduler that sits between the TX data FIFO and the
// SpaceWire character encoder. It arbitrates pending time-codes, FCT
// requests and N-chars (time-code first, then FCT, then N-char). An N-char
// is only fetched or presented while credit is available. Each accepted
// N-char produces one char_sent pulse that is two cycles wide, and the
// credit counter decrements on that pulse.
//
// Ports:
//   pclk_tx, reset_tx   transmit clock, asynchronous active-high reset
//   link_run            link is in Run; nothing is presented while low
//   fct_counter_p       available transmit credit
//   fifo_empty/data/rd  TX FIFO interface; data valid one cycle after fifo_rd
//   tick_in, time_in    time-code request pulse and value
//   send_fct_req        level request for one FCT, dropped after fct_ack
//   fct_ack             one-cycle pulse when the encoder takes the FCT
//   tx_valid/type/data  character presented to the encoder
//                       (type 01 time-code, 10 FCT, 11 N-char)
//   tx_ack              encoder accepted the presented character
//   char_sent           N-char sent indication to the credit counter
module tx_nchar_dispatch #(
    parameter int CHAR_SENT_GAP = 3,
    parameter int DATA_W        = 9
) (
    input  logic              pclk_tx,
    input  logic              reset_tx,
    input  logic              link_run,
    input  logic [5:0]        fct_counter_p,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    input  logic              tick_in,
    input  logic [7:0]        time_in,
    input  logic              send_fct_req,
    output logic              fct_ack,
    output logic              tx_valid,
    output logic [1:0]        tx_type,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ack,
    output logic              char_sent
);

    localparam int CNT_W = $clog2(CHAR_SENT_GAP + 1);

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_TC   = 2'b01;
    localparam logic [1:0] TYPE_FCT  = 2'b10;
    localparam logic [1:0] TYPE_NC   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEND_TC,
        SEND_FCT,
        LOAD,
        WAIT_DATA,
        SEND_NC,
        SENT,
        GAP
    } state_t;

    state_t             state;
    logic               tick_pend;
    logic               tick_renew;
    logic [7:0]         tc_value;
    logic               held;
    logic [DATA_W-1:0]  hold_data;
    logic [CNT_W-1:0]   cnt;
    logic               credit_ok;

    assign credit_ok = (fct_counter_p != 6'd0);

    // Single pending time-code. A newer tick overwrites the stored value.
    // If a tick arrives while a time-code is already being presented, it is
    // a fresh request. tick_renew remembers this so that the ack for the
    // older value does not clear the newer request.
    always_ff @(posedge pclk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            tick_pend  <= 1'b0;
            tick_renew <= 1'b0;
            tc_value   <= 8'd0;
        end else if (tick_in) begin
            tick_pend  <= 1'b1;
            tc_value   <= time_in;
            tick_renew <= (state == SEND_TC) && !tx_ack && link_run;
        end else if (state == SEND_TC && (tx_ack || !link_run)) begin
            if (tx_ack) begin
                tick_pend <= tick_renew;
            end
            tick_renew <= 1'b0;
        end
    end

    // Main scheduler with registered outputs.
    // IDLE re-evaluates priority every cycle. send_fct_req is ignored while
    // fct_ack is high because the requester drops its level only after it
    // sees the ack. A word that was fetched but not acked stays in hold_data
    // with held set, and it is presented again before any new FIFO read.
    // The SENT/GAP tail stretches char_sent and then waits, so the credit
    // counter can apply the decrement before the next credit check.
    always_ff @(posedge pclk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            state     <= IDLE;
            held      <= 1'b0;
            hold_data <= '0;
            cnt       <= '0;
            fifo_rd   <= 1'b0;
            fct_ack   <= 1'b0;
            tx_valid  <= 1'b0;
            tx_type   <= TYPE_NONE;
            tx_data   <= '0;
            char_sent <= 1'b0;
        end else begin
            fifo_rd <= 1'b0;
            fct_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_pend && link_run) begin
                        state    <= SEND_TC;
                        tx_valid <= 1'b1;
                        tx_type  <= TYPE_TC;
                        tx_data  <= {{(DATA_W-8){1'b0}}, tc_value};
                    end else if (send_fct_req && !fct_ack && link_run) begin
                        state    <= SEND_FCT;
                        tx_valid <= 1'b1;
                        tx_type  <= TYPE_FCT;
                        tx_data  <= '0;
                    end else if (link_run && credit_ok && (held || !fifo_empty)) begin
                        if (held) begin
                            state    <= SEND_NC;
                            tx_valid <= 1'b1;
                            tx_type  <= TYPE_NC;
                            tx_data  <= hold_data;
                        end else begin
                            state   <= LOAD;
                            fifo_rd <= 1'b1;
                        end
                    end
                end
                SEND_TC, SEND_FCT: begin
                    if (tx_ack || !link_run) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        tx_type  <= TYPE_NONE;
                        tx_data  <= '0;
                        fct_ack  <= tx_ack && (state == SEND_FCT);
                    end
                end
                LOAD: begin
                    state <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    hold_data <= fifo_data;
                    held      <= 1'b1;
                    if (link_run) begin
                        state    <= SEND_NC;
                        tx_valid <= 1'b1;
                        tx_type  <= TYPE_NC;
                        tx_data  <= fifo_data;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND_NC: begin
                    if (tx_ack) begin
                        state     <= SENT;
                        held      <= 1'b0;
                        tx_valid  <= 1'b0;
                        tx_type   <= TYPE_NONE;
                        tx_data   <= '0;
                        char_sent <= 1'b1;
                        cnt       <= '0;
                    end else if (!link_run) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        tx_type  <= TYPE_NONE;
                        tx_data  <= '0;
                    end
                end
                SENT: begin
                    if (cnt == CNT_W'(1)) begin
                        state     <= GAP;
                        char_sent <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(CHAR_SENT_GAP - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_nchar_dispatch.sv
// tb_tx_nchar_dispatch
// Self-checking bench for tx_nchar_dispatch. The bench models the TX FIFO,
// the character encoder (with optional random ack latency) and the credit
// counter. Expected results come from the ordering and credit rules:
// - time-code before FCT before N-char;
// - N-chars leave in FIFO order;
// - one char_sent pulse per N-char;
// - at most as many N-chars as there is credit.
module tb_tx_nchar_dispatch;

    localparam int CHAR_SENT_GAP = 3;
    localparam int DATA_W        = 9;

    logic              pclk_tx = 1'b0;
    logic              reset_tx = 1'b1;
    logic              link_run = 1'b0;
    logic [5:0]        fct_counter_p;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_rd;
    logic              tick_in = 1'b0;
    logic [7:0]        time_in = 8'd0;
    logic              send_fct_req = 1'b0;
    logic              fct_ack;
    logic              tx_valid;
    logic [1:0]        tx_type;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ack = 1'b0;
    logic              char_sent;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;

    int credit_grant = 0;
    int credit_base = 0;
    int credit_avail;

    bit auto_ack = 1'b1;
    bit rand_ack = 1'b0;
    int wait_cnt = 0;
    int ack_lat = 0;
    logic [10:0] obs_q [$];

    logic cs_prev = 1'b0;
    bit   cs_seen = 1'b0;
    int   cs_run = 0;
    int   cs_total = 0;
    int   rd_count = 0;
    int   fct_count = 0;
    int   valid_cycles = 0;
    int   hi_runs [$];
    int   lo_runs [$];

    tx_nchar_dispatch #(
        .CHAR_SENT_GAP(CHAR_SENT_GAP),
        .DATA_W(DATA_W)
    ) dut (
        .pclk_tx(pclk_tx),
        .reset_tx(reset_tx),
        .link_run(link_run),
        .fct_counter_p(fct_counter_p),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_rd(fifo_rd),
        .tick_in(tick_in),
        .time_in(time_in),
        .send_fct_req(send_fct_req),
        .fct_ack(fct_ack),
        .tx_valid(tx_valid),
        .tx_type(tx_type),
        .tx_data(tx_data),
        .tx_ack(tx_ack),
        .char_sent(char_sent)
    );

    always #5 pclk_tx = ~pclk_tx;

    // Credit counter model: the grant minus the char_sent pulses seen since
    // the grant was set.
    assign credit_avail  = credit_grant - (cs_total - credit_base);
    assign fct_counter_p = (credit_avail > 0) ? credit_avail[5:0] : 6'd0;

    // FIFO model: the word appears one cycle after the read strobe.
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge pclk_tx) begin
        if (fifo_rd && rd_ptr != wr_ptr) begin
            fifo_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Encoder model: acks a presented character after a latency of 0 to 3
    // cycles and logs what it accepted.
    always @(negedge pclk_tx) begin
        if (tx_valid && auto_ack && !tx_ack) begin
            if (wait_cnt >= ack_lat) begin
                tx_ack = 1'b1;
                obs_q.push_back({tx_type, tx_data});
                wait_cnt = 0;
                ack_lat = rand_ack ? int'($urandom_range(0, 3)) : 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            tx_ack = 1'b0;
            if (!tx_valid) wait_cnt = 0;
        end
    end

    // Activity monitor: counts strobes and pulses, and records the high and
    // low run lengths of char_sent.
    always @(negedge pclk_tx) begin
        if (fifo_rd) rd_count++;
        if (tx_valid) valid_cycles++;
        if (fct_ack) fct_count++;
        if (char_sent !== cs_prev) begin
            if (cs_prev) hi_runs.push_back(cs_run);
            else if (cs_seen) lo_runs.push_back(cs_run);
            if (char_sent) begin
                cs_total++;
                cs_seen = 1'b1;
            end
            cs_run = 1;
        end else begin
            cs_run++;
        end
        cs_prev = char_sent;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_word(input logic [8:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic set_credit(input int c);
        credit_grant = c;
        credit_base  = cs_total;
    endtask

    task automatic do_reset();
        reset_tx = 1'b1;
        link_run = 1'b0;
        tick_in = 1'b0;
        send_fct_req = 1'b0;
        auto_ack = 1'b1;
        rand_ack = 1'b0;
        repeat (2) @(negedge pclk_tx);
        reset_tx = 1'b0;
        @(negedge pclk_tx);
    endtask

    task automatic test_reset();
        int rd_b;
        reset_tx = 1'b1;
        set_credit(8);
        @(negedge pclk_tx);
        vectors++;
        if ({fifo_rd, fct_ack, tx_valid, tx_type, tx_data, char_sent} !== 15'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {fifo_rd, fct_ack, tx_valid, tx_type, tx_data, char_sent});
        end
        reset_tx = 1'b0;
        rd_b = rd_count;
        repeat (5) @(negedge pclk_tx);
        vectors++;
        if (tx_valid !== 1'b0 || rd_count != rd_b) begin
            miscompares++;
            $display("[TB] FAIL idle_quiet: got valid=%b reads=%0d expected 0/0",
                     tx_valid, rd_count - rd_b);
        end
    endtask

    task automatic test_in_order();
        logic [8:0] exp_w [3];
        int obs_b, cs_b, hi_b, lo_b, guard;
        logic [10:0] got;
        exp_w[0] = 9'h041; exp_w[1] = 9'h042; exp_w[2] = 9'h100;
        do_reset();
        set_credit(8);
        obs_b = obs_q.size(); cs_b = cs_total; hi_b = hi_runs.size(); lo_b = lo_runs.size();
        for (int k = 0; k < 3; k++) push_word(exp_w[k]);
        link_run = 1'b1;
        guard = 0;
        while (!(hi_runs.size() >= hi_b + 3) && guard < 200) begin
            @(negedge pclk_tx);
            guard++;
        end
        repeat (10) @(negedge pclk_tx);
        vectors++;
        if (obs_q.size() - obs_b != 3) begin
            miscompares++;
            $display("[TB] FAIL order_count: got %0d expected 3", obs_q.size() - obs_b);
        end
        for (int k = 0; k < 3; k++) begin
            got = (obs_q.size() > obs_b + k) ? obs_q[obs_b + k] : 11'h7FF;
            vectors++;
            if (got !== {2'b11, exp_w[k]}) begin
                miscompares++;
                $display("[TB] FAIL order_word%0d: got %h expected %h", k, got, {2'b11, exp_w[k]});
            end
        end
        vectors++;
        if (cs_total - cs_b != 3) begin
            miscompares++;
            $display("[TB] FAIL order_pulses: got %0d expected 3", cs_total - cs_b);
        end
        for (int k = hi_b; k < hi_runs.size(); k++) begin
            vectors++;
            if (hi_runs[k] != 2) begin
                miscompares++;
                $display("[TB] FAIL pulse_width: got %0d expected 2", hi_runs[k]);
            end
        end
        for (int k = lo_b; k < lo_runs.size(); k++) begin
            vectors++;
            if (lo_runs[k] < CHAR_SENT_GAP) begin
                miscompares++;
                $display("[TB] FAIL pulse_gap: got %0d expected >= %0d", lo_runs[k], CHAR_SENT_GAP);
            end
        end
    endtask

    task automatic test_no_credit();
        int rd_b, v_b;
        bit found;
        logic [10:0] got;
        do_reset();
        set_credit(0);
        auto_ack = 1'b0;
        rd_b = rd_count; v_b = valid_cycles;
        push_word(9'h0C3);
        link_run = 1'b1;
        repeat (50) @(negedge pclk_tx);
        vectors++;
        if (rd_count != rd_b || valid_cycles != v_b) begin
            miscompares++;
            $display("[TB] FAIL no_credit_idle: got reads=%0d valid=%0d expected 0/0",
                     rd_count - rd_b, valid_cycles - v_b);
        end
        set_credit(8);
        found = 1'b0;
        got = 11'h7FF;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge pclk_tx);
            if (tx_valid) begin
                found = 1'b1;
                got = {tx_type, tx_data};
            end
        end
        vectors++;
        if (got !== {2'b11, 9'h0C3}) begin
            miscompares++;
            $display("[TB] FAIL credit_return: got %h expected %h", got, {2'b11, 9'h0C3});
        end
        auto_ack = 1'b1;
        repeat (20) @(negedge pclk_tx);
    endtask

    task automatic test_priority();
        int obs_b, cs_b, fct_b, guard;
        logic [10:0] got0, got1, got2;
        do_reset();
        set_credit(8);
        obs_b = obs_q.size(); cs_b = cs_total; fct_b = fct_count;
        push_word(9'h155);
        tick_in = 1'b1; time_in = 8'h2A;
        @(negedge pclk_tx);
        tick_in = 1'b0;
        send_fct_req = 1'b1;
        @(negedge pclk_tx);
        link_run = 1'b1;
        guard = 0;
        while (!(obs_q.size() >= obs_b + 3 && cs_total >= cs_b + 1) && guard < 150) begin
            @(negedge pclk_tx);
            if (fct_ack) send_fct_req = 1'b0;
            guard++;
        end
        repeat (10) begin
            @(negedge pclk_tx);
            if (fct_ack) send_fct_req = 1'b0;
        end
        got0 = (obs_q.size() > obs_b)     ? obs_q[obs_b]     : 11'h7FF;
        got1 = (obs_q.size() > obs_b + 1) ? obs_q[obs_b + 1] : 11'h000;
        got2 = (obs_q.size() > obs_b + 2) ? obs_q[obs_b + 2] : 11'h7FF;
        vectors++;
        if (got0 !== {2'b01, 9'h02A}) begin
            miscompares++;
            $display("[TB] FAIL prio_tc: got %h expected %h", got0, {2'b01, 9'h02A});
        end
        vectors++;
        if (got1[10:9] !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL prio_fct: got type %b expected 10", got1[10:9]);
        end
        vectors++;
        if (got2 !== {2'b11, 9'h155}) begin
            miscompares++;
            $display("[TB] FAIL prio_nc: got %h expected %h", got2, {2'b11, 9'h155});
        end
        vectors++;
        if (fct_count - fct_b != 1 || cs_total - cs_b != 1 || obs_q.size() - obs_b != 3) begin
            miscompares++;
            $display("[TB] FAIL prio_counts: got fct=%0d sent=%0d chars=%0d expected 1/1/3",
                     fct_count - fct_b, cs_total - cs_b, obs_q.size() - obs_b);
        end
    endtask

    task automatic test_tick_overwrite();
        int obs_b, cs_b, guard;
        logic [10:0] got0, got1;
        do_reset();
        set_credit(8);
        auto_ack = 1'b0;
        obs_b = obs_q.size(); cs_b = cs_total;
        push_word(9'h0E7);
        link_run = 1'b1;
        guard = 0;
        while (!tx_valid && guard < 20) begin
            @(negedge pclk_tx);
            guard++;
        end
        tick_in = 1'b1; time_in = 8'h05;
        @(negedge pclk_tx);
        tick_in = 1'b0;
        @(negedge pclk_tx);
        tick_in = 1'b1; time_in = 8'h06;
        @(negedge pclk_tx);
        tick_in = 1'b0;
        repeat (2) @(negedge pclk_tx);
        auto_ack = 1'b1;
        guard = 0;
        while (obs_q.size() < obs_b + 2 && guard < 100) begin
            @(negedge pclk_tx);
            guard++;
        end
        repeat (30) @(negedge pclk_tx);
        got0 = (obs_q.size() > obs_b)     ? obs_q[obs_b]     : 11'h7FF;
        got1 = (obs_q.size() > obs_b + 1) ? obs_q[obs_b + 1] : 11'h7FF;
        vectors++;
        if (got0 !== {2'b11, 9'h0E7}) begin
            miscompares++;
            $display("[TB] FAIL tick_nc_first: got %h expected %h", got0, {2'b11, 9'h0E7});
        end
        vectors++;
        if (got1 !== {2'b01, 9'h006}) begin
            miscompares++;
            $display("[TB] FAIL tick_latest: got %h expected %h", got1, {2'b01, 9'h006});
        end
        vectors++;
        if (obs_q.size() - obs_b != 2 || cs_total - cs_b != 1) begin
            miscompares++;
            $display("[TB] FAIL tick_single: got chars=%0d sent=%0d expected 2/1",
                     obs_q.size() - obs_b, cs_total - cs_b);
        end
    endtask

    task automatic test_link_drop();
        int obs_b, cs_b, rd_b, v_b, guard;
        logic [10:0] got;
        do_reset();
        set_credit(8);
        auto_ack = 1'b0;
        obs_b = obs_q.size();
        push_word(9'h0AB);
        link_run = 1'b1;
        guard = 0;
        while (!tx_valid && guard < 20) begin
            @(negedge pclk_tx);
            guard++;
        end
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 9'h0AB) begin
            miscompares++;
            $display("[TB] FAIL drop_present: got %b/%h expected 1/0ab", tx_valid, tx_data);
        end
        rd_b = rd_count; cs_b = cs_total;
        link_run = 1'b0;
        @(negedge pclk_tx);
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_valid: got %b expected 0", tx_valid);
        end
        v_b = valid_cycles;
        repeat (10) @(negedge pclk_tx);
        vectors++;
        if (valid_cycles != v_b || cs_total != cs_b) begin
            miscompares++;
            $display("[TB] FAIL drop_quiet: got valid=%0d sent=%0d expected 0/0",
                     valid_cycles - v_b, cs_total - cs_b);
        end
        link_run = 1'b1;
        auto_ack = 1'b1;
        guard = 0;
        while (obs_q.size() <= obs_b && guard < 50) begin
            @(negedge pclk_tx);
            guard++;
        end
        repeat (15) @(negedge pclk_tx);
        got = (obs_q.size() > obs_b) ? obs_q[obs_b] : 11'h7FF;
        vectors++;
        if (got !== {2'b11, 9'h0AB}) begin
            miscompares++;
            $display("[TB] FAIL drop_resend: got %h expected %h", got, {2'b11, 9'h0AB});
        end
        vectors++;
        if (rd_count != rd_b || cs_total - cs_b != 1) begin
            miscompares++;
            $display("[TB] FAIL drop_reuse: got reads=%0d sent=%0d expected 0/1",
                     rd_count - rd_b, cs_total - cs_b);
        end
    endtask

    task automatic test_reset_in_sent();
        int obs_b, guard;
        logic [10:0] got;
        do_reset();
        set_credit(8);
        push_word(9'h033);
        link_run = 1'b1;
        guard = 0;
        while (char_sent !== 1'b1 && guard < 30) begin
            @(negedge pclk_tx);
            guard++;
        end
        vectors++;
        if (char_sent !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_reach_sent: got %b expected 1", char_sent);
        end
        reset_tx = 1'b1;
        #1;
        vectors++;
        if ({char_sent, tx_valid, fifo_rd, fct_ack, tx_type} !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_immediate: got %b expected 000000",
                     {char_sent, tx_valid, fifo_rd, fct_ack, tx_type});
        end
        repeat (2) @(negedge pclk_tx);
        reset_tx = 1'b0;
        repeat (3) @(negedge pclk_tx);
        vectors++;
        if ({char_sent, tx_valid, fifo_rd} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL rst_release_idle: got %b expected 000", {char_sent, tx_valid, fifo_rd});
        end
        obs_b = obs_q.size();
        push_word(9'h077);
        guard = 0;
        while (obs_q.size() <= obs_b && guard < 30) begin
            @(negedge pclk_tx);
            guard++;
        end
        got = (obs_q.size() > obs_b) ? obs_q[obs_b] : 11'h7FF;
        vectors++;
        if (got !== {2'b11, 9'h077}) begin
            miscompares++;
            $display("[TB] FAIL rst_resume: got %h expected %h", got, {2'b11, 9'h077});
        end
        repeat (10) @(negedge pclk_tx);
    endtask

    task automatic test_random_credit();
        logic [8:0] exp_q [$];
        logic [8:0] w;
        logic [10:0] got;
        int n, cr, exp_sent, obs_b, cs_b, hi_b, guard;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            exp_q.delete();
            n  = $urandom_range(1, 10);
            cr = $urandom_range(1, 8);
            set_credit(cr);
            rand_ack = 1'b1;
            obs_b = obs_q.size(); cs_b = cs_total; hi_b = hi_runs.size();
            for (int k = 0; k < n; k++) begin
                w = 9'($urandom_range(0, 511));
                exp_q.push_back(w);
                push_word(w);
            end
            exp_sent = (cr < n) ? cr : n;
            link_run = 1'b1;
            guard = 0;
            while (!(obs_q.size() >= obs_b + exp_sent && cs_total >= cs_b + exp_sent)
                   && guard < 30 * n + 60) begin
                @(negedge pclk_tx);
                guard++;
            end
            repeat (40) @(negedge pclk_tx);
            vectors++;
            if (obs_q.size() - obs_b != exp_sent || cs_total - cs_b != exp_sent) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_count: got chars=%0d sent=%0d expected %0d",
                         it, obs_q.size() - obs_b, cs_total - cs_b, exp_sent);
            end
            for (int k = 0; k < exp_sent; k++) begin
                got = (obs_q.size() > obs_b + k) ? obs_q[obs_b + k] : 11'h7FF;
                vectors++;
                if (got !== {2'b11, exp_q[k]}) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_word%0d: got %h expected %h",
                             it, k, got, {2'b11, exp_q[k]});
                end
            end
            vectors++;
            if (wr_ptr - rd_ptr != n - exp_sent) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_left: got %0d expected %0d",
                         it, wr_ptr - rd_ptr, n - exp_sent);
            end
            for (int k = hi_b; k < hi_runs.size(); k++) begin
                vectors++;
                if (hi_runs[k] != 2) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_width: got %0d expected 2", it, hi_runs[k]);
                end
            end
            set_credit(n);
            guard = 0;
            while (!fifo_empty && guard < 30 * n + 60) begin
                @(negedge pclk_tx);
                guard++;
            end
            repeat (20) @(negedge pclk_tx);
        end
    endtask

    initial begin
        $display("[TB] tx_nchar_dispatch bench start");
        test_reset();
        test_in_order();
        test_no_credit();
        test_priority();
        test_tick_overwrite();
        test_link_drop();
        test_reset_in_sent();
        test_random_credit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
